// File: rtl/formula_sum_isqrt_pipe_pkg.sv
// Shared widths and helpers for the parametrised sum-of-square-roots pipeline.
package formula_pipe_pkg;

  localparam int ARG_W  = 32;
  localparam int ROOT_W = 16;
  localparam int max_ch = 16;

  // Result width grows by one bit per doubling of the channel count.
  function automatic int res_w(input int n);
    return (n <= 1) ? ROOT_W : ROOT_W + $clog2(n);
  endfunction

endpackage

// File: rtl/formula_sum_isqrt_pipe_if.sv
// Argument-in / result-out bundle of the sum-of-square-roots pipeline.
interface formula_sum_isqrt_pipe_if #(
  parameter int N_CH = 3
);
  import formula_pipe_pkg::*;

  localparam int RES_W = res_w(N_CH);

  logic                    arg_vld;
  logic [N_CH*ARG_W-1:0]   arg;
  logic [N_CH-1:0]         arg_mask;
  logic                    res_vld;
  logic [RES_W-1:0]        res;
  logic [31:0]             res_cnt;
  logic                    sync_err;

  modport master (
    output arg_vld, arg, arg_mask,
    input  res_vld, res, res_cnt, sync_err
  );

  modport slave (
    input  arg_vld, arg, arg_mask,
    output res_vld, res, res_cnt, sync_err
  );

endinterface

// File: rtl/formula_sum_isqrt_pipe_isqrt.sv
// Pipelined 32-bit integer square root (restoring, two radicand bits per iteration).
// The 16 iterations are spread as evenly as possible over n_pipe_stages registers.
module isqrt
  import formula_pipe_pkg::*;
#(
  parameter int n_pipe_stages = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              x_vld,
  input  logic [ARG_W-1:0]  x,
  output logic              y_vld,
  output logic [ROOT_W-1:0] y
);

  typedef struct packed {
    logic [ARG_W-1:0]  x;
    logic [19:0]       rem;
    logic [ROOT_W-1:0] root;
  } sq_t;

  logic [n_pipe_stages-1:0] vld;
  sq_t                      st  [n_pipe_stages];
  sq_t                      nxt [n_pipe_stages];
  sq_t                      in_st;

  function automatic sq_t sqrt_step(input sq_t a);
    sq_t         r;
    logic [19:0] trial;
    r     = a;
    r.rem = {a.rem[17:0], a.x[ARG_W-1 -: 2]};
    r.x   = {a.x[ARG_W-3:0], 2'b00};
    trial = {2'b00, a.root, 2'b01};
    if (r.rem >= trial) begin
      r.rem  = r.rem - trial;
      r.root = {a.root[ROOT_W-2:0], 1'b1};
    end else begin
      r.root = {a.root[ROOT_W-2:0], 1'b0};
    end
    return r;
  endfunction

  // Stage s owns iterations [16*s/N, 16*(s+1)/N).
  function automatic sq_t run_stage(input sq_t a, input int s);
    sq_t t;
    t = a;
    for (int k = 0; k < ROOT_W; k++) begin
      if (k >= (ROOT_W * s) / n_pipe_stages && k < (ROOT_W * (s + 1)) / n_pipe_stages)
        t = sqrt_step(t);
    end
    return t;
  endfunction

  assign in_st = {x, 20'd0, {ROOT_W{1'b0}}};

  always_comb begin
    nxt    = '{default: '0};
    nxt[0] = run_stage(in_st, 0);
    for (int s = 1; s < n_pipe_stages; s++)
      nxt[s] = run_stage(st[s-1], s);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int s = 0; s < n_pipe_stages; s++)
        st[s] <= '0;
    end else begin
      vld[0] <= x_vld;
      if (x_vld)
        st[0] <= nxt[0];
      for (int s = 1; s < n_pipe_stages; s++) begin
        vld[s] <= vld[s-1];
        if (vld[s-1])
          st[s] <= nxt[s];
      end
    end
  end

  assign y_vld = vld[n_pipe_stages-1];
  assign y     = st[n_pipe_stages-1].root;

endmodule

// File: rtl/formula_sum_isqrt_pipe_tree.sv
// Registered pairwise adder tree, one register level per halving of the operand count.
// Data registers only load when their level carries a valid set.
module sum_tree_pipe #(
  parameter int N     = 3,
  parameter int IN_W  = 16,
  parameter int OUT_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  input  logic [N*IN_W-1:0] in,
  output logic              out_vld,
  output logic [OUT_W-1:0]  out
);

  localparam int LEVELS = (N <= 1) ? 0 : $clog2(N);

  function automatic int cnt_at(input int n, input int lvl);
    int c;
    c = n;
    for (int i = 0; i < lvl; i++)
      c = (c + 1) / 2;
    return c;
  endfunction

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int CNT  = cnt_at(N, l);
    localparam int PREV = cnt_at(N, (l == 0) ? 0 : l - 1);

    logic vld;

    if (l == 0) begin : g_v0
      assign vld = in_vld;
    end else begin : g_vr
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld <= 1'b0;
        else        vld <= g_lvl[l-1].vld;
      end
    end

    for (genvar j = 0; j < CNT; j++) begin : g_elem
      logic [OUT_W-1:0] q;

      if (l == 0) begin : g_leaf
        assign q = OUT_W'(in[IN_W*j +: IN_W]);
      end else if (2*j + 1 < PREV) begin : g_pair
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)
            q <= '0;
          else if (g_lvl[l-1].vld)
            q <= g_lvl[l-1].g_elem[2*j].q + g_lvl[l-1].g_elem[2*j+1].q;
        end
      end else begin : g_pass
        // Odd leftover operand is delayed so it stays aligned with its set.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)
            q <= '0;
          else if (g_lvl[l-1].vld)
            q <= g_lvl[l-1].g_elem[2*j].q;
        end
      end
    end
  end

  assign out_vld = g_lvl[LEVELS].vld;
  assign out     = g_lvl[LEVELS].g_elem[0].q;

endmodule

// File: rtl/formula_sum_isqrt_pipe.sv
// Sum of integer square roots over N_CH channels, one set per cycle, fixed latency
// ISQRT_STAGES + clog2(N_CH) + 1. Masked channels keep their isqrt valid low.
module formula_sum_isqrt_pipe
  import formula_pipe_pkg::*;
#(
  parameter int N_CH         = 3,
  parameter int ISQRT_STAGES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  formula_sum_isqrt_pipe_if.slave bus
);

  localparam int RES_W = res_w(N_CH);

  logic                     rst;
  logic [N_CH-1:0]          x_vld;
  logic [N_CH-1:0]          y_vld;
  logic [ROOT_W-1:0]        y [N_CH];
  logic [ISQRT_STAGES-1:0]  dl_vld;
  logic [N_CH-1:0]          dl_mask [ISQRT_STAGES];
  logic                     exit_vld;
  logic [N_CH-1:0]          exit_mask;
  logic [N_CH*ROOT_W-1:0]   terms;
  logic                     tree_vld;
  logic [RES_W-1:0]         tree_sum;
  logic                     res_vld_q;
  logic [RES_W-1:0]         res_q;
  logic [31:0]              res_cnt_q;
  logic                     sync_err_q;

  assign rst   = !rst_n;
  assign x_vld = {N_CH{bus.arg_vld}} & bus.arg_mask;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    isqrt #(.n_pipe_stages(ISQRT_STAGES)) u_isqrt (
      .clk   (clk),
      .rst   (rst),
      .x_vld (x_vld[i]),
      .x     (bus.arg[ARG_W*i +: ARG_W]),
      .y_vld (y_vld[i]),
      .y     (y[i])
    );
  end

  // Set validity travels beside the isqrts, so an all-masked set still yields a result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_vld <= '0;
      for (int s = 0; s < ISQRT_STAGES; s++)
        dl_mask[s] <= '0;
    end else begin
      dl_vld[0] <= bus.arg_vld;
      if (bus.arg_vld)
        dl_mask[0] <= bus.arg_mask;
      for (int s = 1; s < ISQRT_STAGES; s++) begin
        dl_vld[s] <= dl_vld[s-1];
        if (dl_vld[s-1])
          dl_mask[s] <= dl_mask[s-1];
      end
    end
  end

  assign exit_vld  = dl_vld[ISQRT_STAGES-1];
  assign exit_mask = dl_mask[ISQRT_STAGES-1];

  always_comb begin
    terms = '0;
    for (int i = 0; i < N_CH; i++)
      if (exit_mask[i])
        terms[ROOT_W*i +: ROOT_W] = y[i];
  end

  sum_tree_pipe #(.N(N_CH), .IN_W(ROOT_W), .OUT_W(RES_W)) u_tree (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (exit_vld),
    .in      (terms),
    .out_vld (tree_vld),
    .out     (tree_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_vld_q <= 1'b0;
      res_q     <= '0;
      res_cnt_q <= '0;
    end else begin
      res_vld_q <= tree_vld;
      if (tree_vld)
        res_q <= tree_sum;
      if (res_vld_q)
        res_cnt_q <= res_cnt_q + 32'd1;
    end
  end

  // Any disagreement between an isqrt valid and the side channel is latched until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sync_err_q <= 1'b0;
    else if (y_vld != ({N_CH{exit_vld}} & exit_mask))
      sync_err_q <= 1'b1;
  end

  assign bus.res_vld  = res_vld_q;
  assign bus.res      = res_q;
  assign bus.res_cnt  = res_cnt_q;
  assign bus.sync_err = sync_err_q;

endmodule

// File: tb/tb_formula_sum_isqrt_pipe.sv
// Scoreboard bench for N_CH = 3, 5 and 1 builds of the sum-of-square-roots pipeline.
module tb_formula_sum_isqrt_pipe;
  import formula_pipe_pkg::*;

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  int   failed = 0;
  logic mon_on = 1'b0;
  logic probe_on = 1'b0;
  logic probe_seen = 1'b0;

  exp_t        sb [3][$];
  int unsigned exp_cnt [3] = '{0, 0, 0};
  int          nch [3] = '{3, 5, 1};
  int          lat [3] = '{19, 20, 17};
  string       name [3] = '{"n3", "n5", "n1"};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  formula_sum_isqrt_pipe_if #(.N_CH(3)) if3 ();
  formula_sum_isqrt_pipe_if #(.N_CH(5)) if5 ();
  formula_sum_isqrt_pipe_if #(.N_CH(1)) if1 ();

  formula_sum_isqrt_pipe #(.N_CH(3), .ISQRT_STAGES(16)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));
  formula_sum_isqrt_pipe #(.N_CH(5), .ISQRT_STAGES(16)) dut5 (.clk(clk), .rst_n(rst_n), .bus(if5));
  formula_sum_isqrt_pipe #(.N_CH(1), .ISQRT_STAGES(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  function automatic logic [31:0] ref_isqrt(input logic [31:0] x);
    longint r;
    longint xv;
    xv = longint'(x);
    r  = longint'($floor($sqrt(real'(xv))));
    while (r * r > xv) r--;
    while ((r + 1) * (r + 1) <= xv) r++;
    return 32'(r);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic apply_stimulus(input int id, input logic [511:0] a, input logic [15:0] m);
    exp_t        e;
    logic [31:0] s;
    @(posedge clk);
    #1;
    if3.arg_vld = (id == 0); if3.arg = a[95:0];  if3.arg_mask = m[2:0];
    if5.arg_vld = (id == 1); if5.arg = a[159:0]; if5.arg_mask = m[4:0];
    if1.arg_vld = (id == 2); if1.arg = a[31:0];  if1.arg_mask = m[0:0];
    s = 32'd0;
    for (int i = 0; i < nch[id]; i++)
      if (m[i]) s = s + ref_isqrt(a[32*i +: 32]);
    if (rst_n === 1'b1) begin
      e.val = s;
      e.cyc = cyc;
      sb[id].push_back(e);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    if3.arg_vld = 1'b0;
    if5.arg_vld = 1'b0;
    if1.arg_vld = 1'b0;
  endtask

  task automatic wait_drain(input int id);
    int n;
    n = 0;
    while (sb[id].size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check_eq({name[id], "_drain_pending"}, 32'(sb[id].size()), 32'd0);
  endtask

  task automatic check_output(input int id, input logic vld, input logic [31:0] val,
                              input logic [31:0] cnt);
    exp_t e;
    check_eq({name[id], "_res_cnt"}, cnt, exp_cnt[id]);
    if (vld === 1'b1) begin
      exp_cnt[id]++;
      checks++;
      assert (sb[id].size() > 0) passed++;
      else begin
        failed++;
        $error("[TB] FAIL %s_unexpected observed res=%0d expected no result", name[id], val);
      end
      if (sb[id].size() > 0) begin
        e = sb[id].pop_front();
        check_eq({name[id], "_res"}, val, e.val);
        check_eq({name[id], "_latency"}, 32'(cyc - e.cyc), 32'(lat[id]));
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      check_output(0, if3.res_vld, 32'(if3.res), if3.res_cnt);
      check_output(1, if5.res_vld, 32'(if5.res), if5.res_cnt);
      check_output(2, if1.res_vld, 32'(if1.res), if1.res_cnt);
    end
    if (probe_on && dut3.g_ch[1].u_isqrt.x_vld === 1'b1)
      probe_seen <= 1'b1;
  end

  initial begin
    logic [511:0] a;
    logic [15:0]  m;
    logic [31:0]  r;

    rst_n = 1'b0;
    if3.arg_vld = 1'b0; if3.arg = '0; if3.arg_mask = '0;
    if5.arg_vld = 1'b0; if5.arg = '0; if5.arg_mask = '0;
    if1.arg_vld = 1'b0; if1.arg = '0; if1.arg_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_res_vld", 32'(if3.res_vld), 32'd0);
    check_eq("reset_res", 32'(if3.res), 32'd0);
    check_eq("reset_res_cnt", if3.res_cnt, 32'd0);
    check_eq("reset_sync_err", 32'(if3.sync_err), 32'd0);
    check_eq("reset_n5_res_cnt", if5.res_cnt, 32'd0);
    check_eq("reset_n1_res", 32'(if1.res), 32'd0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_on = 1'b1;

    $display("[TB] single set, all channels");
    a = '0; a[31:0] = 32'd16; a[63:32] = 32'd81; a[95:64] = 32'd144;
    apply_stimulus(0, a, 16'h0007);
    idle();
    wait_drain(0);
    check_eq("t1_res_hold", 32'(if3.res), 32'd25);
    check_eq("t1_res_cnt", if3.res_cnt, 32'd1);

    $display("[TB] masked middle channel");
    probe_on = 1'b1;
    apply_stimulus(0, a, 16'h0005);
    idle();
    wait_drain(0);
    probe_on = 1'b0;
    check_eq("t2_res_hold", 32'(if3.res), 32'd16);
    check_eq("t2_ch1_x_vld_seen", 32'(probe_seen), 32'd0);

    $display("[TB] 100 back-to-back squares");
    for (int k = 0; k < 100; k++) begin
      a = '0;
      for (int i = 0; i < 3; i++) a[32*i +: 32] = 32'((k + i) * (k + i));
      apply_stimulus(0, a, 16'h0007);
    end
    idle();
    wait_drain(0);
    check_eq("t3_res_hold", 32'(if3.res), 32'd300);
    check_eq("t3_res_cnt", if3.res_cnt, 32'd102);

    $display("[TB] maximum arguments then empty mask");
    a = '0; a[95:0] = '1;
    apply_stimulus(0, a, 16'h0007);
    idle();
    wait_drain(0);
    check_eq("t4_res_max", 32'(if3.res), 32'd196605);
    apply_stimulus(0, a, 16'h0000);
    idle();
    wait_drain(0);
    check_eq("t4_res_zero_mask", 32'(if3.res), 32'd0);
    check_eq("t4_res_cnt", if3.res_cnt, 32'd104);

    $display("[TB] reset inside a 30-set stream");
    for (int k = 0; k < 30; k++) begin
      if (k == 10) begin
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
          sb[d].delete();
          exp_cnt[d] = 0;
        end
        #1;
        check_eq("t5_rst_res_vld", 32'(if3.res_vld), 32'd0);
        check_eq("t5_rst_res", 32'(if3.res), 32'd0);
        check_eq("t5_rst_res_cnt", if3.res_cnt, 32'd0);
      end
      if (k == 12) begin
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        if3.arg_vld = 1'b0;
      end
      a = '0;
      for (int i = 0; i < 3; i++) a[32*i +: 32] = $urandom;
      apply_stimulus(0, a, 16'(3'($urandom_range(0, 7))));
    end
    idle();
    wait_drain(0);
    check_eq("t5_res_cnt", if3.res_cnt, 32'd18);

    $display("[TB] random sets on 5- and 1-channel builds");
    for (int id = 1; id < 3; id++) begin
      for (int k = 0; k < 40; k++) begin
        a = '0;
        for (int i = 0; i < nch[id]; i++) begin
          r = $urandom_range(0, 65535);
          case ($urandom_range(0, 3))
            0:       a[32*i +: 32] = $urandom;
            1:       a[32*i +: 32] = r * r;
            2:       a[32*i +: 32] = r * r - 32'd1;
            default: a[32*i +: 32] = 32'hFFFF_FFFF;
          endcase
        end
        m = 16'($urandom);
        if (id == 2 && k < 4) m = 16'(k % 2);
        apply_stimulus(id, a, m);
        if ($urandom_range(0, 4) == 0) idle();
      end
      idle();
      wait_drain(id);
    end

    check_eq("n3_sync_err", 32'(if3.sync_err), 32'd0);
    check_eq("n5_sync_err", 32'(if5.sync_err), 32'd0);
    check_eq("n1_sync_err", 32'(if1.sync_err), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
